// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: pipeline-latch fields in, forwarding
// selects, stall and mult/div status out. The controller uses the slave
// modport; the pipeline (or a bench) drives through the master modport.
interface hazard_ctrl_if #(
    parameter int NREG = 32
);
    localparam int RW = $clog2(NREG);

    // Instruction in X (D/X latch)
    logic [RW-1:0] dx_rs;
    logic [RW-1:0] dx_rt;
    logic [RW-1:0] dx_rd;
    logic          dx_use_rs;
    logic          dx_use_rt;
    logic          dx_use_rd;
    logic          dx_wr;
    logic          dx_sw;
    logic          dx_md;
    // Instruction in M (X/M latch)
    logic [RW-1:0] xm_rd;
    logic          xm_wr;
    logic          xm_lw;
    // Instruction in W (M/W latch)
    logic [RW-1:0] mw_rd;
    logic          mw_wr;
    // Mult/div unit handshake
    logic          md_ready;
    // Controller outputs
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [1:0]    fwd_d;
    logic          wm_fwd;
    logic          stall;
    logic          md_busy;
    logic          md_wb;
    logic [RW-1:0] md_dest;
    logic          md_timeout;

    modport slave (
        input  dx_rs, dx_rt, dx_rd, dx_use_rs, dx_use_rt, dx_use_rd,
        input  dx_wr, dx_sw, dx_md, xm_rd, xm_wr, xm_lw, mw_rd, mw_wr, md_ready,
        output fwd_a, fwd_b, fwd_d, wm_fwd, stall, md_busy, md_wb, md_dest, md_timeout
    );

    modport master (
        output dx_rs, dx_rt, dx_rd, dx_use_rs, dx_use_rt, dx_use_rd,
        output dx_wr, dx_sw, dx_md, xm_rd, xm_wr, xm_lw, mw_rd, mw_wr, md_ready,
        input  fwd_a, fwd_b, fwd_d, wm_fwd, stall, md_busy, md_wb, md_dest, md_timeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline with a multi-cycle
// mult/div unit. Forwarding selects and stall are combinational; a one-deep
// scoreboard plus IDLE/BUSY/WB FSM tracks the outstanding mult/div result and
// claims the W writeback port for exactly one cycle when it arrives.
// Optional feature: define HAZ_WM_BYPASS_EN to enable the W->M store-data
// bypass; without it, a store whose data register is being produced in M is
// held one cycle so the value can come from W instead.
module hazard_ctrl #(
    parameter int NREG          = 32,
    parameter int MD_MAX_CYCLES = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    hazard_ctrl_if.slave bus
);
    localparam int RW = $clog2(NREG);
    localparam int CW = $clog2(MD_MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MD_MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WB   = 2'd2
    } md_state_t;

    md_state_t         r_state;
    md_state_t         w_state_next;
    logic [NREG-1:0]   r_busy;
    logic [RW-1:0]     r_md_dest;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_next;
    logic              r_timeout;
    logic              w_haz_stall;
    logic              w_stall;
    logic              w_issue;
    logic              w_md_wb;
    logic              w_load_use;
    logic              w_sb_stall;
    logic              w_struct_stall;
    logic              w_sw_extra;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic f_match(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a == b) && (a != '0);
    endfunction

    // M has priority over W because it holds the younger producer.
    function automatic logic [1:0] f_fwd(input logic use_src, input logic [RW-1:0] src,
                                         input logic [RW-1:0] m_rd, input logic m_wr,
                                         input logic [RW-1:0] w_rd, input logic w_wr);
        if (use_src && m_wr && f_match(src, m_rd))
            return 2'd1;
        else if (use_src && w_wr && f_match(src, w_rd))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign bus.fwd_a = f_fwd(bus.dx_use_rs, bus.dx_rs, bus.xm_rd, bus.xm_wr, bus.mw_rd, bus.mw_wr);
    assign bus.fwd_b = f_fwd(bus.dx_use_rt, bus.dx_rt, bus.xm_rd, bus.xm_wr, bus.mw_rd, bus.mw_wr);
    assign bus.fwd_d = f_fwd(bus.dx_use_rd, bus.dx_rd, bus.xm_rd, bus.xm_wr, bus.mw_rd, bus.mw_wr);

    // Interlocks that do not depend on the FSM output cycle (WB stall added below).
    always_comb begin
        w_load_use = bus.xm_lw && bus.xm_wr &&
                     ((bus.dx_use_rs && f_match(bus.dx_rs, bus.xm_rd)) ||
                      (bus.dx_use_rt && f_match(bus.dx_rt, bus.xm_rd)) ||
                      (bus.dx_use_rd && !bus.dx_sw && f_match(bus.dx_rd, bus.xm_rd)));
        w_sb_stall = (bus.dx_use_rs && r_busy[bus.dx_rs]) ||
                     (bus.dx_use_rt && r_busy[bus.dx_rt]) ||
                     (bus.dx_use_rd && r_busy[bus.dx_rd]) ||
                     (bus.dx_wr     && r_busy[bus.dx_rd]);
        w_struct_stall = bus.dx_md && (r_state != S_IDLE);
`ifdef HAZ_WM_BYPASS_EN
        w_sw_extra = 1'b0;
`else
        w_sw_extra = bus.dx_sw && bus.xm_wr && f_match(bus.dx_rd, bus.xm_rd);
`endif
        w_haz_stall = w_load_use || w_sb_stall || w_struct_stall || w_sw_extra;
    end

    // FSM next state, issue decision and WB-cycle outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        w_stall      = w_haz_stall;
        w_issue      = 1'b0;
        w_md_wb      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.dx_md && !w_haz_stall) begin
                    w_issue      = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.md_ready)
                    w_state_next = S_WB;
            end
            S_WB: begin
                w_md_wb      = 1'b1;
                w_stall      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Watchdog counter: saturates at the limit so the sticky flag cannot wrap.
    always_comb begin
        w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    end

    // Scoreboard, destination latch and watchdog.
    always_ff @(posedge clock) begin
        // NOTE: the scoreboard is a plain flop vector, so it is cleared by reset like any other state.
        if (!reset_n) begin
            r_busy    <= '0;
            r_md_dest <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_issue) begin
                if (bus.dx_rd != '0)
                    r_busy[bus.dx_rd] <= 1'b1;
                r_md_dest <= bus.dx_rd;
                r_cnt     <= '0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= w_cnt_next;
                if (w_cnt_next == CNT_MAX)
                    r_timeout <= 1'b1;
            end
            if (r_state == S_WB)
                r_busy[r_md_dest] <= 1'b0;
        end
    end

`ifdef HAZ_WM_BYPASS_EN
    logic          r_m_sw;
    logic [RW-1:0] r_m_sw_rd;

    // Track the store entering M; a stall injects a bubble instead.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_m_sw    <= 1'b0;
            r_m_sw_rd <= '0;
        end else begin
            r_m_sw    <= bus.dx_sw && !w_stall;
            r_m_sw_rd <= bus.dx_rd;
        end
    end

    assign bus.wm_fwd = r_m_sw && bus.mw_wr && f_match(r_m_sw_rd, bus.mw_rd);
`else
    assign bus.wm_fwd = 1'b0;
`endif

    assign bus.stall      = w_stall;
    assign bus.md_busy    = (r_state != S_IDLE);
    assign bus.md_wb      = w_md_wb;
    assign bus.md_dest    = r_md_dest;
    assign bus.md_timeout = r_timeout;
endmodule
